// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-to-decode instruction handshake (valid/ready, instr, instr_pc)
interface fetch_unit_if #(
  parameter int ADDR_W = 12
) ();
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, 1-cycle imem request, 2-entry queue to decode
// Optional misaligned-redirect fault enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hold,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [31:0]       idata,
  fetch_unit_if.master      dec,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              fault_q, fault_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [31:0]       fifo_instr_q [2];
  logic [ADDR_W-1:0] fifo_pc_q    [2];

  logic              misalign;
  logic [ADDR_W-1:0] target_pc;
  logic              take_redirect;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_pc = redirect_pc;
  assign misalign  = redirect_valid && (state_q != S_FAULT) && (redirect_pc[1:0] != 2'b00);
`else
  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign misalign  = 1'b0;
`endif

  // Once faulted the stage is frozen, so later redirects are ignored too.
  assign take_redirect = redirect_valid && (state_q != S_FAULT);
  assign pop           = (count_q != 2'd0) && dec.instr_ready;
  assign push          = inflight_q && !take_redirect;
  assign occupancy     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue         = (state_q == S_RUN) && en && !hold && !redirect_valid
                         && (occupancy < 3'd2);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    fault_d       = fault_q | misalign;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (misalign)  state_d = S_FAULT;
        else if (en)   state_d = S_RUN;
      end
      S_RUN: begin
        if (misalign)  state_d = S_FAULT;
        else if (!en)  state_d = S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (take_redirect && !misalign) begin
      pc_d = target_pc;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(4);
      inflight_pc_d = pc_q;
    end

    if (take_redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      fifo_instr_q  <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q       <= fault_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= idata;
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      end
    end
  end

  // The issue credit rule must never let a capture land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == 2'd2)));

  assign iaddr           = pc_q;
  assign dec.instr_valid = (count_q != 2'd0);
  assign dec.instr       = fifo_instr_q[rd_ptr_q];
  assign dec.instr_pc    = fifo_pc_q[rd_ptr_q];
  assign fault           = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit with a registered imem model
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        en0, hold0, rv0, ready0;
  logic [11:0] rpc0;
  logic [11:0] iaddr0, iaddr1;
  logic [31:0] idata0, idata1;
  logic        fault0, fault1;

  int n_cmp;
  int n_err;

  fetch_unit_if #(.ADDR_W(12)) dec0 ();
  fetch_unit_if #(.ADDR_W(12)) dec1 ();

  assign dec0.instr_ready = ready0;
  assign dec1.instr_ready = 1'b1;

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .en             (en0),
    .hold           (hold0),
    .redirect_valid (rv0),
    .redirect_pc    (rpc0),
    .iaddr          (iaddr0),
    .idata          (idata0),
    .dec            (dec0.master),
    .fault          (fault0)
  );

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'hFFC)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .en             (1'b1),
    .hold           (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (12'h000),
    .iaddr          (iaddr1),
    .idata          (idata1),
    .dec            (dec1.master),
    .fault          (fault1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'h100 + {22'd0, a[11:2]};
  endfunction

  always @(posedge clk) begin
    idata0 <= mem_word(iaddr0);
    idata1 <= mem_word(iaddr1);
  end

  typedef struct {
    logic        en;
    logic        hold;
    logic        rdy;
    logic        rv;
    logic [11:0] rpc;
    logic        ev;
    logic [11:0] epc;
    logic [31:0] einstr;
    logic [11:0] eiaddr;
    logic        efault;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic hold, input logic rdy,
                              input logic rv, input logic [11:0] rpc, input logic ev,
                              input logic [11:0] epc, input logic [11:0] eiaddr,
                              input logic efault);
    vec_t v;
    v.en = en; v.hold = hold; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = mem_word(epc); v.eiaddr = eiaddr;
    v.efault = efault;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk);
      #1;
      en0 = tbl[i].en; hold0 = tbl[i].hold; ready0 = tbl[i].rdy;
      rv0 = tbl[i].rv; rpc0 = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("row%0d_valid", i), {31'd0, dec0.instr_valid}, {31'd0, tbl[i].ev});
      check($sformatf("row%0d_iaddr", i), {20'd0, iaddr0}, {20'd0, tbl[i].eiaddr});
      check($sformatf("row%0d_fault", i), {31'd0, fault0}, {31'd0, tbl[i].efault});
      if (tbl[i].ev) begin
        check($sformatf("row%0d_instr", i), dec0.instr, tbl[i].einstr);
        check($sformatf("row%0d_pc", i), {20'd0, dec0.instr_pc}, {20'd0, tbl[i].epc});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, dec0.instr_valid}, 32'd0);
    check({tag, "_iaddr"}, {20'd0, iaddr0}, 32'd0);
    check({tag, "_instr"}, dec0.instr, 32'd0);
    check({tag, "_pc"}, {20'd0, dec0.instr_pc}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault0}, 32'd0);
    check({tag, "_iaddr1"}, {20'd0, iaddr1}, 32'h0000_0FFC);
  endtask

  int seg_a_end, seg_fill_end, seg_b_end;
  logic [11:0] wrap_pc   [5];
  logic        wrap_v    [5];
  logic [11:0] wrap_addr [5];

  initial begin
    n_cmp = 0; n_err = 0;
    en0 = 1'b0; hold0 = 1'b0; rv0 = 1'b0; ready0 = 1'b0; rpc0 = 12'h000;
    rst = 1'b0;

    // Stream, 6-cycle stall, redirect, then misaligned redirect.
    add(1,0,1,0,12'h000, 0,12'h000,12'h000,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h000,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h004,0);
    for (int c = 3; c <= 5; c++)
      add(1,0,1,0,12'h000, 1,12'(4*(c-3)),12'(4*(c-1)),0);
    for (int c = 6; c <= 11; c++)
      add(1,0,0,0,12'h000, 1,12'h00C,12'h014,0);
    for (int c = 12; c <= 15; c++)
      add(1,0,1,0,12'h000, 1,12'(12'h00C + 4*(c-12)),12'(12'h014 + 4*(c-12)),0);
    add(1,0,0,1,12'h040, 1,12'h01C,12'h024,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h040,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h044,0);
    add(1,0,1,0,12'h000, 1,12'h040,12'h048,0);
    add(1,0,1,0,12'h000, 1,12'h044,12'h04C,0);
    add(1,0,1,1,12'h042, 1,12'h048,12'h050,0);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int c = 22; c <= 25; c++)
      add(1,0,1,0,12'h000, 0,12'h000,12'h050,1);
`else
    add(1,0,1,0,12'h000, 0,12'h000,12'h040,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h044,0);
    add(1,0,1,0,12'h000, 1,12'h040,12'h048,0);
    add(1,0,1,0,12'h000, 1,12'h044,12'h04C,0);
`endif
    seg_a_end = tbl.size();

    // Fill the queue with decode stalled, ahead of the async reset.
    add(1,0,0,0,12'h000, 0,12'h000,12'h000,0);
    add(1,0,0,0,12'h000, 0,12'h000,12'h000,0);
    add(1,0,0,0,12'h000, 0,12'h000,12'h004,0);
    add(1,0,0,0,12'h000, 1,12'h000,12'h008,0);
    add(1,0,0,0,12'h000, 1,12'h000,12'h008,0);
    seg_fill_end = tbl.size();

    // Restart from RESET_PC with hold, including hold while a capture is pending.
    add(1,1,1,0,12'h000, 0,12'h000,12'h000,0);
    add(1,1,1,0,12'h000, 0,12'h000,12'h000,0);
    add(1,1,1,0,12'h000, 0,12'h000,12'h000,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h000,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h004,0);
    add(1,1,1,0,12'h000, 1,12'h000,12'h008,0);
    add(1,1,1,0,12'h000, 1,12'h004,12'h008,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h008,0);
    add(1,0,1,0,12'h000, 0,12'h000,12'h00C,0);
    add(1,0,1,0,12'h000, 1,12'h008,12'h010,0);
    seg_b_end = tbl.size();

    wrap_v[0] = 0; wrap_pc[0] = 12'h000; wrap_addr[0] = 12'hFFC;
    wrap_v[1] = 0; wrap_pc[1] = 12'h000; wrap_addr[1] = 12'h000;
    wrap_v[2] = 1; wrap_pc[2] = 12'hFFC; wrap_addr[2] = 12'h004;
    wrap_v[3] = 1; wrap_pc[3] = 12'h000; wrap_addr[3] = 12'h008;
    wrap_v[4] = 1; wrap_pc[4] = 12'h004; wrap_addr[4] = 12'h00C;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    run_rows(0, seg_a_end);

    @(negedge clk);
    rst = 1'b0;
    en0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_rows(seg_a_end, seg_fill_end);

    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    en0 = 1'b0; hold0 = 1'b0; ready0 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run_rows(seg_fill_end, seg_b_end);

    // Second instance starts at FFC and must wrap to 000.
    @(negedge clk);
    rst = 1'b0;
    en0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("wrap%0d_valid", k), {31'd0, dec1.instr_valid}, {31'd0, wrap_v[k]});
      check($sformatf("wrap%0d_iaddr", k), {20'd0, iaddr1}, {20'd0, wrap_addr[k]});
      if (wrap_v[k]) begin
        check($sformatf("wrap%0d_pc", k), {20'd0, dec1.instr_pc}, {20'd0, wrap_pc[k]});
        check($sformatf("wrap%0d_instr", k), dec1.instr, mem_word(wrap_pc[k]));
      end
    end
    check("wrap_fault", {31'd0, fault1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
